sm3_pad_blk_buf: RTL and testbench

Receiver for the sm3_pad_core padded-output interface (pad_otpt_d/vld/lst plus the pad_otpt_ena flow-control enable). Collects padded words into complete 512-bit SM3 message blocks in a two-entry ping-pong buffer. Hands each block to the compression/expansion stage over a valid/ready handshake. Throttles the pad core via pad_otpt_ena_o whenever both buffers are occupied.

---
 rtl/sm3_pad_blk_buf.sv | 133 +++++++++++++
 tb/tb_sm3_pad_blk_buf.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sm3_pad_blk_buf.sv
// Purpose: collects padded SM3 words from sm3_pad_core into 512-bit blocks held in a two-entry ping-pong buffer.
// Latency: a block is presented on blk_vld_o the cycle after its closing word is accepted; back-to-back reads give 1 block/cycle.
// Backpressure: pad_otpt_ena_o drops while the write-side buffer is still occupied; blk_* holds stable until blk_rdy_i.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   pad_otpt_d_i        padded word (WORD_DW bits), first word lands in blk_d_o[511 -: WORD_DW]
//   pad_otpt_vld_i      word valid; accepted only when pad_otpt_ena_o is also high
//   pad_otpt_lst_i      last word of the padded message
//   pad_otpt_ena_o      flow-control enable back to the pad core
//   blk_d_o/blk_vld_o/blk_lst_o/blk_rdy_i   block output, valid/ready handshake
//   err_o, err_clr_i    sticky protocol error flag and its synchronous clear

module sm3_pad_blk_buf #(
    parameter int WORD_DW = 32  // 32 or 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WORD_DW-1:0] pad_otpt_d_i,
    input  logic               pad_otpt_vld_i,
    input  logic               pad_otpt_lst_i,
    output logic               pad_otpt_ena_o,
    output logic [511:0]       blk_d_o,
    output logic               blk_vld_o,
    output logic               blk_lst_o,
    input  logic               blk_rdy_i,
    output logic               err_o,
    input  logic               err_clr_i
);

    localparam int BLK_WORDS = 512 / WORD_DW;
    localparam int WCW       = $clog2(BLK_WORDS);
    localparam logic [WCW-1:0] LAST_SLOT = WCW'(BLK_WORDS - 1);

    // Block storage is deliberately not reset; full_q qualifies it.
    logic [511:0]   blk_buf_q [2];

    logic [1:0]     full_q, full_d;
    logic [1:0]     lst_q, lst_d;
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           err_q, err_d;

    logic           acc;
    logic           drop;
    logic           early_lst;
    logic           close;
    logic           rd;

    // Enable depends only on registered state so the pad core never sees a
    // combinational path from its own valid.
    assign pad_otpt_ena_o = ~full_q[wr_ptr_q];

    assign acc       = pad_otpt_vld_i & pad_otpt_ena_o;
    assign drop      = pad_otpt_vld_i & ~pad_otpt_ena_o;
    assign early_lst = acc & pad_otpt_lst_i & (wcnt_q != LAST_SLOT);
    assign close     = acc & ((wcnt_q == LAST_SLOT) | pad_otpt_lst_i);

    assign blk_vld_o = full_q[rd_ptr_q];
    assign blk_d_o   = blk_buf_q[rd_ptr_q];
    assign blk_lst_o = lst_q[rd_ptr_q];
    assign err_o     = err_q;

    assign rd = blk_vld_o & blk_rdy_i;

    always_comb begin
        full_d   = full_q;
        lst_d    = lst_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wcnt_d   = wcnt_q;
        err_d    = err_q;

        // A read and a closing write always target different buffers: a write
        // needs full[wr_ptr]=0 and a read needs full[rd_ptr]=1.
        if (rd) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
        end

        if (acc) begin
            wcnt_d = wcnt_q + 1'b1;
        end

        if (close) begin
            full_d[wr_ptr_q] = 1'b1;
            lst_d[wr_ptr_q]  = pad_otpt_lst_i;
            wr_ptr_d         = ~wr_ptr_q;
            wcnt_d           = '0;
        end

        // Set has priority over the clear request.
        if (drop | early_lst) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= '0;
            lst_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            wcnt_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            full_q   <= full_d;
            lst_q    <= lst_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wcnt_q   <= wcnt_d;
            err_q    <= err_d;
        end
    end

    // Word write; an early last also zero-fills every slot after it so the
    // block closes in the same cycle.
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int s = 0; s < BLK_WORDS; s++) begin
                if (s == int'(wcnt_q)) begin
                    blk_buf_q[wr_ptr_q][511 - s*WORD_DW -: WORD_DW] <= pad_otpt_d_i;
                end else if (early_lst && (s > int'(wcnt_q))) begin
                    blk_buf_q[wr_ptr_q][511 - s*WORD_DW -: WORD_DW] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm3_pad_blk_buf.sv
// Purpose: self-checking bench for sm3_pad_blk_buf using a block-queue reference model.
// Latency: model expects a closed block visible the cycle after its closing word.
// Backpressure: model predicts enable low exactly when two closed blocks are unread.

module tb_sm3_pad_blk_buf;

    localparam int W   = 32;
    localparam int BLK = 512 / W;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] d;
    logic         vld;
    logic         lst;
    logic         ena;
    logic [511:0] blk_d;
    logic         blk_vld;
    logic         blk_lst;
    logic         rdy;
    logic         err;
    logic         clr;

    sm3_pad_blk_buf #(.WORD_DW(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pad_otpt_d_i   (d),
        .pad_otpt_vld_i (vld),
        .pad_otpt_lst_i (lst),
        .pad_otpt_ena_o (ena),
        .blk_d_o        (blk_d),
        .blk_vld_o      (blk_vld),
        .blk_lst_o      (blk_lst),
        .blk_rdy_i      (rdy),
        .err_o          (err),
        .err_clr_i      (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: closed-but-unread blocks in order, plus the block being assembled.
    logic [511:0] q_dat [$];
    logic         q_lst [$];
    logic [511:0] cur_blk;
    int           cur_cnt;
    logic         m_err;

    int errors = 0;
    int checks = 0;

    logic [511:0] abc_blk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_dat.delete();
        q_lst.delete();
        cur_blk = '0;
        cur_cnt = 0;
        m_err   = 1'b0;
    endtask

    // One clock: check outputs against the model, take the edge, advance the model.
    task automatic cyc();
        logic e_ena, e_vld, a, r, drp, early;
        e_ena = (q_dat.size() < 2);
        e_vld = (q_dat.size() > 0);
        chk("ena", {511'b0, ena}, {511'b0, e_ena});
        chk("vld", {511'b0, blk_vld}, {511'b0, e_vld});
        chk("err", {511'b0, err}, {511'b0, m_err});
        if (e_vld) begin
            chk("dat", blk_d, q_dat[0]);
            chk("lst", {511'b0, blk_lst}, {511'b0, q_lst[0]});
        end
        @(posedge clk);
        a     = vld & e_ena;
        r     = e_vld & rdy;
        drp   = vld & ~e_ena;
        early = a & lst & (cur_cnt < BLK - 1);
        if (r) begin
            void'(q_dat.pop_front());
            void'(q_lst.pop_front());
        end
        if (a) begin
            cur_blk[511 - cur_cnt*W -: W] = d;
            cur_cnt++;
            if (cur_cnt == BLK || lst) begin
                // Unwritten slots are already zero, which is the early-last fill.
                q_dat.push_back(cur_blk);
                q_lst.push_back(lst);
                cur_blk = '0;
                cur_cnt = 0;
            end
        end
        if (drp | early) m_err = 1'b1;
        else if (clr)    m_err = 1'b0;
        #1;
    endtask

    task automatic send_abc();
        for (int i = 0; i < BLK; i++) begin
            d   = (i == 0) ? 32'h61626380 : ((i == BLK - 1) ? 32'h00000018 : 32'h0);
            lst = (i == BLK - 1);
            vld = 1'b1;
            rdy = 1'b1;
            cyc();
        end
        vld = 1'b0;
        lst = 1'b0;
        chk("abc_vld", {511'b0, blk_vld}, {511'b0, 1'b1});
        chk("abc_dat", blk_d, abc_blk);
        chk("abc_lst", {511'b0, blk_lst}, {511'b0, 1'b1});
        chk("abc_err", {511'b0, err}, 512'b0);
        cyc();
        chk("abc_gone", {511'b0, blk_vld}, 512'b0);
        cyc();
    endtask

    initial begin
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
        rst_n = 1'b0;
        d = '0; vld = 1'b0; lst = 1'b0; rdy = 1'b0; clr = 1'b0;
        model_reset();
        #23;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_ena", {511'b0, ena}, {511'b0, 1'b1});
        chk("rst_vld", {511'b0, blk_vld}, 512'b0);
        chk("rst_err", {511'b0, err}, 512'b0);

        // Single "abc" block
        send_abc();

        // Two-block message with no downstream ready
        rdy = 1'b0;
        for (int i = 0; i < 2*BLK; i++) begin
            d = $urandom; vld = 1'b1; lst = (i == 2*BLK - 1);
            cyc();
        end
        // Overflow word while disabled
        d = $urandom; vld = 1'b1; lst = 1'b0;
        cyc();
        vld = 1'b0; clr = 1'b1;
        cyc();
        clr = 1'b0;
        cyc();
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) cyc();

        // Early last on word 5
        for (int i = 0; i < 5; i++) begin
            d = $urandom; vld = 1'b1; lst = (i == 4);
            cyc();
        end
        vld = 1'b0; lst = 1'b0;
        cyc(); cyc();
        clr = 1'b1; cyc(); clr = 1'b0;

        // Continuous streaming, 4 blocks, always ready
        for (int i = 0; i < 4*BLK; i++) begin
            d = $urandom; vld = 1'b1; lst = (i == 4*BLK - 1);
            cyc();
        end
        vld = 1'b0; lst = 1'b0;
        cyc(); cyc();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            d   = $urandom;
            vld = ($urandom_range(9, 0) < 7);
            lst = ($urandom_range(19, 0) == 0);
            rdy = ($urandom_range(1, 0) == 1);
            clr = ($urandom_range(15, 0) == 0);
            cyc();
        end
        vld = 1'b0; lst = 1'b0; clr = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 4; i++) cyc();

        // Reset mid-block, then fresh "abc"
        for (int i = 0; i < 7; i++) begin
            d = $urandom; vld = 1'b1; lst = 1'b0; rdy = 1'b1;
            cyc();
        end
        vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", {511'b0, blk_vld}, 512'b0);
        chk("mid_rst_ena", {511'b0, ena}, {511'b0, 1'b1});
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc();
        send_abc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
